// File: rtl/cfg_cmd_parser.sv
// Byte-stream command parser feeding the config register file.
// Ports: rx byte in (valid/ready), tx readback out (valid/ready),
//   register file write/read ports, cmd_error pulse.
// Optional: define CFG_CMD_TIMEOUT_EN for the inter-byte abort.
module cfg_cmd_parser #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  WRITE_CMD      = 8'h57,
  parameter logic [7:0]  READ_CMD       = 8'h52
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] write_addr,
  output logic [7:0] write_data,
  output logic [7:0] read_addr,
  output logic       write,
  output logic       read,
  input  logic [7:0] read_data,
  output logic       cmd_error
);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WR, RD, RD_WAIT, TX
  } state_t;

  state_t state;
  logic   op_wr;
  logic   rx_fire;
  logic   tx_fire;
  logic   tmo_hit;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

`ifdef CFG_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (state == ADDR || state == DATA)
                 && !rx_fire && (tmo_cnt == TMO_MAX);

  // Counts idle cycles while a packet is half-received.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state == ADDR || state == DATA)
                 && !rx_fire && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // rx_ready is registered, so it is set together with the
  // transition into IDLE/ADDR/DATA and cleared on the way out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_wr      <= 1'b0;
      rx_ready   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      read_addr  <= '0;
      write      <= 1'b0;
      read       <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      write     <= 1'b0;
      read      <= 1'b0;
      cmd_error <= 1'b0;
      unique case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            if (rx_data == WRITE_CMD) begin
              op_wr <= 1'b1;
              state <= ADDR;
            end else if (rx_data == READ_CMD) begin
              op_wr <= 1'b0;
              state <= ADDR;
            end else begin
              cmd_error <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            if (op_wr) begin
              write_addr <= rx_data;
              state      <= DATA;
            end else begin
              read_addr <= rx_data;
              read      <= 1'b1;
              rx_ready  <= 1'b0;
              state     <= RD;
            end
          end else if (tmo_hit) begin
            cmd_error <= 1'b1;
            state     <= IDLE;
          end
        end
        DATA: begin
          if (rx_fire) begin
            write_data <= rx_data;
            write      <= 1'b1;
            rx_ready   <= 1'b0;
            state      <= WR;
          end else if (tmo_hit) begin
            cmd_error <= 1'b1;
            state     <= IDLE;
          end
        end
        WR: begin
          rx_ready <= 1'b1;
          state    <= IDLE;
        end
        RD: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          tx_data  <= read_data;
          tx_valid <= 1'b1;
          state    <= TX;
        end
        TX: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          rx_ready <= 1'b0;
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_cmd_parser.sv
// Directed bench for cfg_cmd_parser with a small register
// file model on the write/read ports.
module tb_cfg_cmd_parser;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic [7:0] read_addr;
  logic       write;
  logic       read;
  logic [7:0] read_data;
  logic       cmd_error;

  int n_chk;
  int n_pass;
  int wr_cnt;
  int rd_cnt;
  int err_cnt;

  logic [7:0] mem [256];

  cfg_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .write      (write),
    .read       (read),
    .read_data  (read_data),
    .cmd_error  (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) mem[write_addr] <= write_data;
    if (read) read_data <= mem[read_addr];
    if (write) wr_cnt++;
    if (read) rd_cnt++;
    if (cmd_error) err_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [39:0] obs,
                     input logic [39:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", 40'(rx_ready), 40'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int w0;
  int r0;
  int e0;
  int n;

  initial begin
    n_chk = 0; n_pass = 0;
    wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[5]    = 8'h5C;
    mem[1]    = 8'h11;
    read_data = 8'h00;
    reset_n   = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 40'({rx_ready, tx_valid, tx_data, write,
        read, write_addr, write_data, read_addr, cmd_error}),
        40'd0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("rdy_idle", 40'(rx_ready), 40'd1);

    // write 57,03,A5
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'hA5);
    chk("wr_strobe", 40'(write), 40'd1);
    chk("wr_addr", 40'(write_addr), 40'h03);
    chk("wr_data", 40'(write_data), 40'hA5);
    chk("wr_rdy", 40'(rx_ready), 40'd0);
    step();
    chk("wr_off", 40'(write), 40'd0);
    chk("wr_noerr", 40'(err_cnt), 40'd0);
    chk("wr_notx", 40'(tx_valid), 40'd0);
    chk("wr_cnt", 40'(wr_cnt), 40'd1);

    // read 52,03 -> A5
    send_byte(8'h52);
    send_byte(8'h03);
    chk("rd_strobe", 40'(read), 40'd1);
    chk("rd_addr", 40'(read_addr), 40'h03);
    chk("rd_nowr", 40'(write), 40'd0);
    step();
    chk("rd_off", 40'(read), 40'd0);
    chk("rd_txlo", 40'(tx_valid), 40'd0);
    step();
    chk("rd_txv", 40'(tx_valid), 40'd1);
    chk("rd_txd", 40'(tx_data), 40'hA5);
    tx_ready = 1'b1;
    step();
    chk("rd_txdone", 40'(tx_valid), 40'd0);
    tx_ready = 1'b0;

    // illegal 00, then write 10 <- 3C
    e0 = err_cnt;
    send_byte(8'h00);
    chk("ill_err", 40'(cmd_error), 40'd1);
    chk("ill_rdy", 40'(rx_ready), 40'd1);
    send_byte(8'h57);
    chk("ill_pulse", 40'(cmd_error), 40'd0);
    send_byte(8'h10);
    send_byte(8'h3C);
    chk("ill_wr", 40'(write), 40'd1);
    chk("ill_waddr", 40'(write_addr), 40'h10);
    chk("ill_wdata", 40'(write_data), 40'h3C);
    chk("ill_ecnt", 40'(err_cnt - e0), 40'd1);
    step();

    // read 05 under backpressure, 57 waiting
    send_byte(8'h52);
    send_byte(8'h05);
    n = 0;
    while (!tx_valid && n < 10) begin
      step();
      n++;
    end
    chk("bp_lat", 40'(n), 40'd2);
    rx_data  = 8'h57;
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_txv", 40'(tx_valid), 40'd1);
      chk("bp_txd", 40'(tx_data), 40'h5C);
      chk("bp_rdy", 40'(rx_ready), 40'd0);
      step();
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("bp_txdone", 40'(tx_valid), 40'd0);
    chk("bp_rdy1", 40'(rx_ready), 40'd1);
    send_byte(8'h57);
    send_byte(8'h0B);
    send_byte(8'h77);
    chk("bp_wr", 40'(write), 40'd1);
    chk("bp_waddr", 40'(write_addr), 40'h0B);
    step();

    // reset mid-packet
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h07);
    reset_n = 1'b0;
    #1;
    chk("mid_rst", 40'({rx_ready, tx_valid, tx_data, write,
        read, write_addr, write_data, read_addr, cmd_error}),
        40'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    e0 = err_cnt;
    send_byte(8'h20);
    chk("mid_err", 40'(cmd_error), 40'd1);
    step();
    chk("mid_nowr", 40'(wr_cnt - w0), 40'd0);
    chk("mid_ecnt", 40'(err_cnt - e0), 40'd1);

`ifdef CFG_CMD_TIMEOUT_EN
    r0 = rd_cnt;
    e0 = err_cnt;
    send_byte(8'h52);
    n = 0;
    while (!cmd_error && n < 20) begin
      step();
      n++;
    end
    chk("tmo_err", 40'(cmd_error), 40'd1);
    chk("tmo_when", 40'(n), 40'd16);
    step();
    chk("tmo_ecnt", 40'(err_cnt - e0), 40'd1);
    chk("tmo_nord", 40'(rd_cnt - r0), 40'd0);
    send_byte(8'h52);
    send_byte(8'h01);
    chk("tmo_rd", 40'(read), 40'd1);
    step();
    step();
    chk("tmo_txd", 40'(tx_data), 40'h11);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
`else
    r0 = rd_cnt;
    send_byte(8'h52);
    repeat (40) step();
    chk("wait_rdy", 40'(rx_ready), 40'd1);
    chk("wait_noerr", 40'(cmd_error), 40'd0);
    send_byte(8'h01);
    chk("wait_rd", 40'(read), 40'd1);
    step();
    step();
    chk("wait_txd", 40'(tx_data), 40'h11);
    chk("wait_rcnt", 40'(rd_cnt - r0), 40'd1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
